basic_gates: RTL and testbench
==============================

BASIC_GATES -- requirements
Module: basic_gates

Interface
REQ-001 Parameter WIDTH, default 1, sets the bit width of both operands and every gate output (legal range 1..64).
REQ-002 Parameter CNT_W, default 16, sets the width of the statistics counters.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port a  input  WIDTH  operand A.
REQ-006 Port b  input  WIDTH  operand B.
REQ-007 Port and_out  output  WIDTH  registered a & b.
REQ-008 Port or_out  output  WIDTH  registered a | b.
REQ-009 Port xor_out  output  WIDTH  registered a ^ b.
REQ-010 Port nand_out  output  WIDTH  registered ~(a & b).
REQ-011 Port nor_out  output  WIDTH  registered ~(a | b).
REQ-012 Port xnor_out  output  WIDTH  registered ~(a ^ b).
REQ-013 Port not_a  output  WIDTH  registered ~a.
REQ-014 Port not_b  output  WIDTH  registered ~b.
REQ-015 Port in_change  output  1  registered pulse: the sampled {a,b} differs from the previous sample.
REQ-016 Port eq_cnt  output  CNT_W  count of cycles where the sampled a == b.
REQ-017 Port chg_cnt  output  CNT_W  count of cycles where in_change was asserted.

Function
REQ-018 All gate operations SHALL be bitwise across WIDTH; no bit affects another.
REQ-019 Every output SHALL be registered; a value applied at edge N SHALL appear on the outputs after edge N (1-cycle latency).
REQ-020 There SHALL be no combinational path from a/b to any output.
REQ-021 The block SHALL hold previous-sample registers a_q and b_q.
REQ-022 in_change SHALL assert for one cycle when {a,b} != {a_q,b_q} at an edge, and deassert otherwise.
REQ-023 Holding constant inputs SHALL keep in_change low from the second cycle onward.
REQ-024 Each counter SHALL increment by 1 per qualifying cycle and saturate at 2^CNT_W-1; it SHALL never wrap.
REQ-025 Outputs SHALL be mutually consistent every cycle: nand_out == ~and_out, nor_out == ~or_out, xnor_out == ~xor_out.
REQ-026 X/Z inputs are outside scope; behaviour for them is undefined.

Reset
REQ-027 While rst is high at a clock edge, the gate outputs SHALL load the a=0,b=0 result: and/or/xor = 0; nand/nor/xnor/not_a/not_b = all ones.
REQ-028 Reset SHALL clear a_q and b_q to 0, clear in_change, and clear eq_cnt and chg_cnt to 0.
REQ-029 The first edge after reset release SHALL compare the inputs against the zero a_q/b_q; inputs of 0,0 SHALL produce no in_change.
REQ-030 Reset asserted mid-operation SHALL override any counter increment in that cycle.

Configuration
REQ-031 Macro BASIC_GATES_STATS_EN, when defined, SHALL compile in the eq_cnt/chg_cnt counters.
REQ-032 When BASIC_GATES_STATS_EN is undefined, eq_cnt and chg_cnt SHALL remain as ports and be tied to constant 0.
REQ-033 Gate outputs and in_change SHALL be identical with and without BASIC_GATES_STATS_EN.

Verification
REQ-034 Reset then a=0,b=0 -> and=0 or=0 xor=0 nand=1 nor=1 xnor=1 not_a=1 not_b=1, in_change=0.
REQ-035 Truth table (WIDTH=1): 00, 01, 10, 11 applied one per cycle -> one cycle later AND 0001, OR 0111, XOR 0110, NAND 1110, NOR 1000, XNOR 1001.
REQ-036 Alternate 01/10 for 6 cycles -> in_change=1 each cycle; chg_cnt=6 and eq_cnt=0 (STATS_EN defined).
REQ-037 Repeat 00/11 twice, then hold 11 for 3 cycles -> eq_cnt=7; in_change=0 during the hold after its first cycle.
REQ-038 CNT_W=2 with a==b for 6 cycles -> eq_cnt saturates at 3; rst pulse -> all counters 0 and outputs at their REQ-027 values.
REQ-039 WIDTH=4 with a=4'b1100, b=4'b1010 -> and=1000 or=1110 xor=0110 nand=0111 nor=0001 xnor=1001 not_a=0011 not_b=0101.

Source files
------------

// File: rtl/basic_gates.sv
// Registered bitwise gate bank with input-change detection and optional statistics.
// Define BASIC_GATES_STATS_EN to compile in the eq_cnt/chg_cnt counters; otherwise they read 0.
module basic_gates #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] or_out,
  output logic [WIDTH-1:0] xor_out,
  output logic [WIDTH-1:0] nand_out,
  output logic [WIDTH-1:0] nor_out,
  output logic [WIDTH-1:0] xnor_out,
  output logic [WIDTH-1:0] not_a,
  output logic [WIDTH-1:0] not_b,
  output logic             in_change,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             change_now;

  assign change_now = ({a, b} != {a_q, b_q});

  // Reset loads the a=0,b=0 gate results so nand/nor/xnor/not stay complementary.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_out   <= '0;
      or_out    <= '0;
      xor_out   <= '0;
      nand_out  <= '1;
      nor_out   <= '1;
      xnor_out  <= '1;
      not_a     <= '1;
      not_b     <= '1;
      a_q       <= '0;
      b_q       <= '0;
      in_change <= 1'b0;
    end else begin
      and_out   <= a & b;
      or_out    <= a | b;
      xor_out   <= a ^ b;
      nand_out  <= ~(a & b);
      nor_out   <= ~(a | b);
      xnor_out  <= ~(a ^ b);
      not_a     <= ~a;
      not_b     <= ~b;
      a_q       <= a;
      b_q       <= b;
      in_change <= change_now;
    end
  end

`ifdef BASIC_GATES_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counters advance on the same edge that registers the qualifying sample and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      eq_cnt  <= '0;
      chg_cnt <= '0;
    end else begin
      if ((a == b) && (eq_cnt != CNT_MAX)) begin
        eq_cnt <= eq_cnt + CNT_W'(1);
      end
      if (change_now && (chg_cnt != CNT_MAX)) begin
        chg_cnt <= chg_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign eq_cnt  = '0;
  assign chg_cnt = '0;
`endif

endmodule

// File: tb/tb_basic_gates.sv
// Randomized and directed bench for basic_gates at WIDTH=1/CNT_W=16 and WIDTH=4/CNT_W=2.
module tb_basic_gates;

`ifdef BASIC_GATES_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;

  logic [0:0]  and1, or1, xor1, nand1, nor1, xnor1, na1, nb1;
  logic        ic1;
  logic [15:0] eq1, chg1;
  logic [3:0]  and4, or4, xor4, nand4, nor4, xnor4, na4, nb4;
  logic        ic4;
  logic [1:0]  eq4, chg4;

  int checks = 0;
  int errors = 0;

  // Reference model: last accepted operands, expected change flag and counts.
  logic [0:0] sa1, sb1;
  logic [3:0] sa4, sb4;
  logic       mic1, mic4;
  int         me1, mc1, me4, mc4;

  basic_gates #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .and_out(and1), .or_out(or1), .xor_out(xor1), .nand_out(nand1),
    .nor_out(nor1), .xnor_out(xnor1), .not_a(na1), .not_b(nb1),
    .in_change(ic1), .eq_cnt(eq1), .chg_cnt(chg1)
  );

  basic_gates #(.WIDTH(4), .CNT_W(2)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4),
    .and_out(and4), .or_out(or4), .xor_out(xor4), .nand_out(nand4),
    .nor_out(nor4), .xnor_out(xnor4), .not_a(na4), .not_b(nb4),
    .in_change(ic4), .eq_cnt(eq4), .chg_cnt(chg4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int satInc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic checkAll();
    logic [0:0] t1;
    logic [3:0] t4;
    t1 = sa1 & sb1;     checkOutput("w1 and", and1, t1);
    t1 = sa1 | sb1;     checkOutput("w1 or", or1, t1);
    t1 = sa1 ^ sb1;     checkOutput("w1 xor", xor1, t1);
    t1 = ~(sa1 & sb1);  checkOutput("w1 nand", nand1, t1);
    t1 = ~(sa1 | sb1);  checkOutput("w1 nor", nor1, t1);
    t1 = ~(sa1 ^ sb1);  checkOutput("w1 xnor", xnor1, t1);
    t1 = ~sa1;          checkOutput("w1 not_a", na1, t1);
    t1 = ~sb1;          checkOutput("w1 not_b", nb1, t1);
    checkOutput("w1 in_change", ic1, mic1);
    checkOutput("w1 eq_cnt", eq1, STATS ? me1 : 0);
    checkOutput("w1 chg_cnt", chg1, STATS ? mc1 : 0);
    t4 = sa4 & sb4;     checkOutput("w4 and", and4, t4);
    t4 = sa4 | sb4;     checkOutput("w4 or", or4, t4);
    t4 = sa4 ^ sb4;     checkOutput("w4 xor", xor4, t4);
    t4 = ~(sa4 & sb4);  checkOutput("w4 nand", nand4, t4);
    t4 = ~(sa4 | sb4);  checkOutput("w4 nor", nor4, t4);
    t4 = ~(sa4 ^ sb4);  checkOutput("w4 xnor", xnor4, t4);
    t4 = ~sa4;          checkOutput("w4 not_a", na4, t4);
    t4 = ~sb4;          checkOutput("w4 not_b", nb4, t4);
    checkOutput("w4 in_change", ic4, mic4);
    checkOutput("w4 eq_cnt", eq4, STATS ? me4 : 0);
    checkOutput("w4 chg_cnt", chg4, STATS ? mc4 : 0);
  endtask

  task automatic applyStimulus(input logic r, input logic [0:0] va1, input logic [0:0] vb1,
                               input logic [3:0] va4, input logic [3:0] vb4);
    rst = r; a1 = va1; b1 = vb1; a4 = va4; b4 = vb4;
    @(posedge clk);
    if (r) begin
      sa1 = '0; sb1 = '0; sa4 = '0; sb4 = '0;
      mic1 = 1'b0; mic4 = 1'b0;
      me1 = 0; mc1 = 0; me4 = 0; mc4 = 0;
    end else begin
      mic1 = ({va1, vb1} != {sa1, sb1});
      mic4 = ({va4, vb4} != {sa4, sb4});
      sa1 = va1; sb1 = vb1; sa4 = va4; sb4 = vb4;
      if (va1 == vb1) me1 = satInc(me1, 65535);
      if (mic1)       mc1 = satInc(mc1, 65535);
      if (va4 == vb4) me4 = satInc(me4, 3);
      if (mic4)       mc4 = satInc(mc4, 3);
    end
    #1;
    checkAll();
  endtask

  initial begin
    logic [3:0] tt_and, tt_or, tt_xor, tt_nand, tt_nor, tt_xnor;
    logic [3:0] ra, rb;
    logic [0:0] r1a, r1b;
    tt_and = 4'b0001; tt_or = 4'b0111; tt_xor = 4'b0110;
    tt_nand = 4'b1110; tt_nor = 4'b1000; tt_xnor = 4'b1001;

    // Reset, then zero inputs must not raise in_change.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    checkOutput("rst nand", nand1, 1'b1);
    checkOutput("rst not_b4", nb4, 4'hF);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    checkOutput("post-rst in_change", ic1, 1'b0);

    // One-bit truth table, 00 01 10 11 in order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'(i >> 1), 1'(i), 4'h0, 4'h0);
      checkOutput("tt and", and1, tt_and[3-i]);
      checkOutput("tt or", or1, tt_or[3-i]);
      checkOutput("tt xor", xor1, tt_xor[3-i]);
      checkOutput("tt nand", nand1, tt_nand[3-i]);
      checkOutput("tt nor", nor1, tt_nor[3-i]);
      checkOutput("tt xnor", xnor1, tt_xnor[3-i]);
    end

    // Alternating 01/10 changes every cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'(i % 2), 1'((i + 1) % 2), 4'h0, 4'h0);
      checkOutput("alt in_change", ic1, 1'b1);
    end
    checkOutput("alt chg_cnt", chg1, STATS ? 16'd6 : 16'd0);
    checkOutput("alt eq_cnt", eq1, 16'd0);

    // 00/11 twice then hold 11.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, (i >= 4 || i % 2 == 1) ? 1'b1 : 1'b0,
                    (i >= 4 || i % 2 == 1) ? 1'b1 : 1'b0, 4'h0, 4'h0);
      if (i >= 5) checkOutput("hold in_change", ic1, 1'b0);
    end
    checkOutput("hold eq_cnt", eq1, STATS ? 16'd7 : 16'd0);

    // Four-bit operand pattern.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1100, 4'b1010);
    checkOutput("w4 dir and", and4, 4'b1000);
    checkOutput("w4 dir or", or4, 4'b1110);
    checkOutput("w4 dir xor", xor4, 4'b0110);
    checkOutput("w4 dir nand", nand4, 4'b0111);
    checkOutput("w4 dir nor", nor4, 4'b0001);
    checkOutput("w4 dir xnor", xnor4, 4'b1001);
    checkOutput("w4 dir not_a", na4, 4'b0011);
    checkOutput("w4 dir not_b", nb4, 4'b0101);

    // Two-bit counter saturation, then reset pulse.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'(i * 3), 4'(i * 3));
    end
    checkOutput("sat eq_cnt", eq4, STATS ? 2'd3 : 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h5, 4'h5);
    checkOutput("sat rst eq_cnt", eq4, 2'd0);
    checkOutput("sat rst chg_cnt", chg4, 2'd0);
    checkOutput("sat rst xnor", xnor4, 4'hF);

    // Random traffic with biased equality and sparse resets.
    for (int i = 0; i < 300; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      r1a = 1'($urandom_range(0, 1));
      r1b = ($urandom_range(0, 2) == 0) ? r1a : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 3) begin
        ra = sa4; rb = sb4; r1a = sa1; r1b = sb1;
      end
      applyStimulus(($urandom_range(0, 39) == 0), r1a, r1b, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
